// File: rtl/pb_serial_frontend.sv
// rtl/pb_serial_frontend.sv - synchronise, debounce and strobe the push-button bit clock with its data bit
module pb_serial_frontend #(
  parameter int DB_CYCLES = 2,
  parameter int CNT_W     = $clog2(DB_CYCLES + 1)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clkpb,
  input  logic       serin,
  output logic       strobe,
  output logic       serout,
  output logic       pb_db,
  output logic [7:0] press_cnt
);

  typedef enum logic [1:0] {IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic             pb_m, pb_s;
  logic             ser_m, ser_s;
  state_t           st;
  logic [CNT_W-1:0] cnt;

  // Serial line idles high, so its synchroniser resets to 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      pb_m  <= 1'b0;
      pb_s  <= 1'b0;
      ser_m <= 1'b1;
      ser_s <= 1'b1;
    end else begin
      pb_m  <= clkpb;
      pb_s  <= pb_m;
      ser_m <= serin;
      ser_s <= ser_m;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st        <= IDLE;
      cnt       <= '0;
      strobe    <= 1'b0;
      serout    <= 1'b1;
      pb_db     <= 1'b0;
      press_cnt <= 8'd0;
    end else begin
      strobe <= 1'b0;
      case (st)
        IDLE: begin
          if (pb_s) begin
            cnt <= CNT_ONE;
            if (DB_CYCLES == 1) begin
              st        <= PRESSED;
              pb_db     <= 1'b1;
              strobe    <= 1'b1;
              serout    <= ser_s;
              press_cnt <= press_cnt + 8'd1;
            end else begin
              st <= PRESS_WAIT;
            end
          end else begin
            cnt <= '0;
          end
        end
        PRESS_WAIT: begin
          if (!pb_s) begin
            st  <= IDLE;
            cnt <= '0;
          end else if (cnt == CNT_LAST) begin
            st        <= PRESSED;
            cnt       <= '0;
            pb_db     <= 1'b1;
            strobe    <= 1'b1;
            serout    <= ser_s;
            press_cnt <= press_cnt + 8'd1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        PRESSED: begin
          if (!pb_s) begin
            cnt <= CNT_ONE;
            if (DB_CYCLES == 1) begin
              st    <= IDLE;
              pb_db <= 1'b0;
            end else begin
              st <= RELEASE_WAIT;
            end
          end
        end
        RELEASE_WAIT: begin
          // A short low run is release bounce: go back without a second strobe.
          if (pb_s) begin
            st  <= PRESSED;
            cnt <= '0;
          end else if (cnt == CNT_LAST) begin
            st    <= IDLE;
            cnt   <= '0;
            pb_db <= 1'b0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: begin
          st    <= IDLE;
          cnt   <= '0;
          pb_db <= 1'b0;
        end
      endcase
    end
  end

endmodule
